regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_clr_fsm.sv | 67 ++++++
 rtl/regfile_param.sv | 95 +++++++++
 tb/tb_regfile_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default parameters for the register file
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NREAD    = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_LED_W    = 8;

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - clear sweep FSM, zeroes one register index per cycle
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic [ADDR_W-1:0] sweep_idx,
    output logic              sweep_we,
    output logic              clr_busy,
    output logic              clr_done
);

    // The last index of the array is all ones because DEPTH is a power of two.
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_e        state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;

    // State and sweep index registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next state, index advance and Moore outputs.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sweep_we = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                end
            end
            SWEEP: begin
                sweep_we = 1'b1;
                clr_busy = 1'b1;
                idx_n    = idx + ADDR_W'(1);
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign sweep_idx = idx;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - multi-port register file with byte writes, bypass, clear sweep and debug tap
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int LED_W    = DEF_LED_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W/8-1:0]     wr_be,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done,
    input  logic [ADDR_W-1:0]       led_sel,
    output logic [LED_W-1:0]        led_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];

    logic [ADDR_W-1:0] sweep_idx;
    logic              sweep_we;
    logic              wr_ok;
    logic              wr_is_zero_reg;
    logic [DATA_W-1:0] wr_merged;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .sweep_idx (sweep_idx),
        .sweep_we  (sweep_we),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    // A write lands only outside reset and outside the sweep, never into a hardwired zero register.
    assign wr_is_zero_reg = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok          = rst_n && we && !clr_busy && !wr_is_zero_reg;

    // Byte-merge the incoming data over the current contents; shared by storage and bypass.
    always_comb begin
        wr_merged = regs[wr_addr];
        for (int b = 0; b < NBYTE; b++) begin
            if (wr_be[b]) begin
                wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Storage update: reset clears everything, the sweep zeroes one entry, otherwise accept the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (sweep_we) begin
            regs[sweep_idx] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    // Independent combinational read ports with write-through bypass.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            ((ZERO_REG != 0) && (a == '0)) ? '0 :
            (wr_ok && (a == wr_addr))      ? wr_merged :
                                             regs[a];
    end

    // Debug tap: top bits of the selected stored register, one cycle late, no bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_o <= '0;
        end else begin
            led_o <= regs[led_sel][DATA_W-1 -: LED_W];
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized self-checking bench with behavioural register file model
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    logic [4:0]  led_sel;
    logic [7:0]  led_o;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    logic [31:0] m_reg [32];
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_pos   = 0;
    logic [7:0]  m_led   = 8'h00;

    regfile_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .led_sel  (led_sel),
        .led_o    (led_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic bit write_taken();
        return rst_n && we && !m_busy && (wr_addr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (write_taken() && a == wr_addr) return merge(m_reg[a], wr_data, wr_be);
        return m_reg[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (!m_valid) return;
        chk("rd_port0", rd_data[31:0], exp_rd(rd_addr[4:0]));
        chk("rd_port1", rd_data[63:32], exp_rd(rd_addr[9:5]));
        chk("clr_busy", {31'b0, clr_busy}, {31'b0, m_busy});
        chk("clr_done", {31'b0, clr_done}, {31'b0, m_done});
        chk("led_o", {24'b0, led_o}, {24'b0, m_led});
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_pos   = 0;
            m_led   = 8'h00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_led = m_reg[led_sel][31:24];
            if (write_taken()) m_reg[wr_addr] = merge(m_reg[wr_addr], wr_data, wr_be);
            if (m_busy) begin
                m_reg[m_pos] = 32'h0;
                m_pos++;
                if (m_pos == 32) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (clr_req) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
    endtask

    // inputs are set just after a falling edge; outputs checked before the rising edge
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cycle();
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk(name, rd_data[31:0], 32'h0);
            cycle();
        end
    endtask

    task automatic count_sweep(input int ncyc, output int busy_n, output int done_n, input bit try_write);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            clr_req = (i == 0);
            we = try_write && (i == 6);
            wr_addr = 5'd4; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
            #1;
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            cycle();
        end
        clr_req = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        int busy_n;
        int done_n;
        rst_n = 1'b0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        wr_be = '0; clr_req = 1'b0; led_sel = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("reset_rd0", rd_data[31:0], 32'h0);
        chk("reset_busy", {31'b0, clr_busy}, 32'h0);
        chk("reset_done", {31'b0, clr_done}, 32'h0);
        chk("reset_led", {24'b0, led_o}, 32'h0);

        // write then read back, plus same-cycle bypass on port 1
        rd_addr = {5'd5, 5'd0};
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        #1;
        chk("bypass_r5", rd_data[63:32], 32'hDEADBEEF);
        cycle();
        we = 1'b0; rd_addr = {5'd0, 5'd5};
        #1;
        chk("read_r5", rd_data[31:0], 32'hDEADBEEF);
        cycle();

        // byte-enable merge
        do_write(5'd7, 32'h11223344, 4'hF);
        rd_addr = {5'd0, 5'd7};
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        #1;
        chk("merge_bypass_r7", rd_data[31:0], 32'h11BB33DD);
        cycle();
        we = 1'b0;
        #1;
        chk("merge_r7", rd_data[31:0], 32'h11BB33DD);
        cycle();

        // hardwired zero register
        rd_addr = {5'd0, 5'd0};
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        #1;
        chk("r0_same_cycle", rd_data[31:0], 32'h0);
        chk("r0_same_cycle_p1", rd_data[63:32], 32'h0);
        cycle();
        we = 1'b0;
        #1;
        chk("r0_after", rd_data[31:0], 32'h0);
        cycle();

        // debug tap latency
        led_sel = 5'd3;
        do_write(5'd3, 32'hA5000000, 4'hF);
        cycle();
        #1;
        chk("led_r3", {24'b0, led_o}, 32'h000000A5);

        // fill and clear; write during the sweep is lost
        for (int a = 1; a < 32; a++) do_write(5'(a), 32'h01010101 * a + 32'h1000, 4'hF);
        count_sweep(40, busy_n, done_n, 1'b1);
        chk("sweep_busy_cycles", busy_n, 32);
        chk("sweep_done_pulses", done_n, 1);
        check_all_zero("zero_after_clear");

        // reset in the middle of a sweep
        for (int a = 1; a < 32; a++) do_write(5'(a), 32'hF0F0F0F0 ^ a, 4'hF);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("abort_busy", {31'b0, clr_busy}, 32'h0);
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (clr_done) done_n++;
            cycle();
        end
        chk("abort_no_done", done_n, 0);
        check_all_zero("zero_after_abort");
        count_sweep(40, busy_n, done_n, 1'b0);
        chk("resweep_busy_cycles", busy_n, 32);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_n   = ($urandom_range(0, 249) != 0);
            rd_addr = 10'($urandom);
            we      = $urandom_range(0, 1) != 0;
            wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr[4:0] : 5'($urandom);
            wr_data = $urandom;
            wr_be   = 4'($urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            led_sel = 5'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
